load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data memory word width.
REQ-002 Parameter ADDR_WIDTH, default 8, data memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  memory request present this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-010 ld_data  output  DATA_WIDTH  aligned, extended load result.
REQ-011 stall  output  1  pipeline must hold the request this cycle.
REQ-012 misalign  output  1  misaligned-access flag.
REQ-013 dmem_MemRW  output  1  data memory write enable.
REQ-014 dmem_Addr  output  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2].
REQ-015 dmem_DataW  output  DATA_WIDTH  word to write.
REQ-016 dmem_DataR  input  DATA_WIDTH  word read combinationally from memory.

Function
REQ-017 FSM states IDLE and RMW_WR; reset state IDLE.
REQ-018 Load, IDLE: dmem_MemRW=0; ld_data combinational from dmem_DataR in the same cycle; byte lane selected by req_addr[1:0], halfword lane by req_addr[1]; sign-extend for B/H, zero-extend for BU/HU, pass-through for W.
REQ-019 Word store, IDLE: dmem_MemRW=1, dmem_DataW=req_wdata, single cycle, stall=0.
REQ-020 Sub-word store, IDLE: dmem_MemRW=0, stall=1, dmem_DataR captured into merge register at clock edge; next state RMW_WR.
REQ-021 RMW_WR: dmem_MemRW=1, dmem_DataW = captured word with addressed lane replaced by low bits of req_wdata; stall=0; next state IDLE.
REQ-022 Request inputs in RMW_WR belong to the stalled request; no new request is accepted until IDLE.
REQ-023 req_valid=0 or illegal funct3 (011, 110, 111): dmem_MemRW=0, stall=0, ld_data=0, no state change.
REQ-024 Misaligned means H with req_addr[0]=1, or W with req_addr[1:0]!=00.
REQ-025 Address bits above ADDR_WIDTH+1 are ignored (wrap within memory).
REQ-026 ld_data is 0 whenever req_we=1.

Reset
REQ-027 On rst: state=IDLE, merge register=0, stall=0, misalign=0, dmem_MemRW=0, ld_data=0, dmem_DataW=0.
REQ-028 rst asserted in RMW_WR aborts the store; no write is issued.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN.
REQ-030 Defined: misaligned access asserts misalign for that cycle, forces dmem_MemRW=0, ld_data=0, stall=0, no FSM transition.
REQ-031 Undefined: misalign tied 0; req_addr low bits forced to natural alignment (H: bit0=0, W: bits1:0=00) and the access proceeds.

Structure
REQ-032 Shared package holds funct3 encodings, FSM state encoding and lane-select constants.
REQ-033 One sub-module, lsu_align: combinational load extract/extend and store lane merge; FSM and merge register stay in top level.

Verification
REQ-034 Memory word 0x80FF7F01 at addr 0x10; LB 0x10 -> 0x00000001; LB 0x12 -> 0xFFFFFFFF; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF.
REQ-035 SW 0xDEADBEEF to 0x20 -> one cycle, MemRW=1, Addr=0x08, stall=0; readback LW = 0xDEADBEEF.
REQ-036 Word 0x11223344 at 0x30; SB 0xAA to 0x31 -> stall=1 one cycle, then write 0x1122AA44; SH 0xBEEF to 0x32 -> 0xBEEFAA44.
REQ-037 With LSU_MISALIGN_TRAP_EN: LW 0x41 -> misalign=1, no write, ld_data=0; without: LW 0x41 returns word at 0x40.
REQ-038 rst pulse during RMW_WR of SB to 0x30 -> memory unchanged, state IDLE, stall=0.
REQ-039 Back-to-back SB 0x50, LW 0x50 -> LW in cycle after RMW_WR returns merged word.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg : funct3 encodings, FSM state and lane constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int LANE_BYTE_W = 8;
  localparam int LANE_HALF_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Forces the byte offset down to the natural boundary of the access size
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align : load lane extract/extend and store lane merge (combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [1:0]            i_off,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_ld,
  output logic [DATA_WIDTH-1:0] o_st
);

  logic [4:0]             w_bsh;
  logic [4:0]             w_hsh;
  logic [LANE_BYTE_W-1:0] w_byte;
  logic [LANE_HALF_W-1:0] w_half;

  assign w_bsh  = {i_off, 3'b000};
  assign w_hsh  = {i_off[1], 4'b0000};
  assign w_byte = i_rdata[w_bsh +: LANE_BYTE_W];
  assign w_half = i_rdata[w_hsh +: LANE_HALF_W];

  always_comb begin
    o_ld = i_rdata;
    o_st = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_ld = {{(DATA_WIDTH-LANE_BYTE_W){w_byte[LANE_BYTE_W-1] & ~i_unsigned}}, w_byte};
        o_st = i_word;
        o_st[w_bsh +: LANE_BYTE_W] = i_wdata[LANE_BYTE_W-1:0];
      end
      SZ_HALF: begin
        o_ld = {{(DATA_WIDTH-LANE_HALF_W){w_half[LANE_HALF_W-1] & ~i_unsigned}}, w_half};
        o_st = i_word;
        o_st[w_hsh +: LANE_HALF_W] = i_wdata[LANE_HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : RV32 load/store unit, sub-word stores via read-modify-write
// Option macro: LSU_MISALIGN_TRAP_EN (flag misaligned accesses instead of aligning)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  stall,
  output logic                  misalign,
  output logic                  dmem_MemRW,
  output logic [ADDR_WIDTH-1:0] dmem_Addr,
  output logic [DATA_WIDTH-1:0] dmem_DataW,
  input  logic [DATA_WIDTH-1:0] dmem_DataR
);

  lsu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_merge;

  logic                  w_legal;
  logic [1:0]            w_size;
  logic [1:0]            w_off;
  logic                  w_trap;
  logic                  w_go;
  logic [DATA_WIDTH-1:0] w_ld_ext;
  logic [DATA_WIDTH-1:0] w_st_merged;
  logic                  w_unused;

  assign w_legal   = req_valid && f3_legal(req_funct3);
  assign w_size    = f3_size(req_funct3);
  assign w_off     = align_off(w_size, req_addr[1:0]);
  assign dmem_Addr = req_addr[ADDR_WIDTH+1:2];
  assign w_unused  = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_unal;
  assign w_unal = ((w_size == SZ_HALF) && req_addr[0]) ||
                  ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_trap = w_legal && w_unal;
`else
  assign w_trap = 1'b0;
`endif

  assign w_go = w_legal && !w_trap;

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_size    (w_size),
    .i_unsigned(req_funct3[2]),
    .i_off     (w_off),
    .i_rdata   (dmem_DataR),
    .i_word    (r_merge),
    .i_wdata   (req_wdata),
    .o_ld      (w_ld_ext),
    .o_st      (w_st_merged)
  );

  // Sub-word store: capture the current word, write the merged word next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_merge <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go && req_we && (w_size != SZ_WORD)) begin
            r_merge <= dmem_DataR;
            r_state <= ST_RMW_WR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_data    = '0;
    stall      = 1'b0;
    misalign   = 1'b0;
    dmem_MemRW = 1'b0;
    dmem_DataW = '0;
    if (!rst) begin
      misalign = w_trap;
      if (r_state == ST_RMW_WR) begin
        dmem_MemRW = 1'b1;
        dmem_DataW = w_st_merged;
      end else if (w_go) begin
        if (!req_we) begin
          ld_data = w_ld_ext;
        end else if (w_size == SZ_WORD) begin
          dmem_MemRW = 1'b1;
          dmem_DataW = req_wdata;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed + randomized bench with a behavioural LSU model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] ld_data, dmem_DataW, dmem_DataR;
  logic        stall, misalign, dmem_MemRW;
  logic [7:0]  dmem_Addr;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  // expected outputs for the current cycle
  logic        e_chk = 1'b0;
  logic [31:0] e_ld, e_dw;
  logic        e_stall, e_mis, e_we;
  logic [7:0]  e_addr;

  // captured outputs of the last transaction
  logic [31:0] c_ld, c_dw, c2_dw;
  logic        c_stall, c_mis, c_we, c2_we, c2_stall;
  logic [7:0]  c_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dmem_DataR = mem[dmem_Addr];

  load_store_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ld_data   (ld_data),
    .stall     (stall),
    .misalign  (misalign),
    .dmem_MemRW(dmem_MemRW),
    .dmem_Addr (dmem_Addr),
    .dmem_DataW(dmem_DataW),
    .dmem_DataR(dmem_DataR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_chk) begin
      check("ld_data",    ld_data,           e_ld);
      check("stall",      32'(stall),        32'(e_stall));
      check("misalign",   32'(misalign),     32'(e_mis));
      check("dmem_MemRW", 32'(dmem_MemRW),   32'(e_we));
      check("dmem_Addr",  32'(dmem_Addr),    32'(e_addr));
      check("dmem_DataW", dmem_DataW,        e_dw);
    end
  end

  // One request through the model; abort pulses rst during the write cycle
  task automatic do_txn(input logic v, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input bit abort);
    bit legal, uns, unal, trap, sub;
    int sz, bo;
    logic [7:0] widx;
    longint unsigned word, mask, val, merged;
    legal  = v && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                   f3 == 3'b100 || f3 == 3'b101);
    sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns    = f3[2];
    unal   = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    trap   = TRAP_EN && legal && unal;
    bo     = int'(a[1:0]) - (int'(a[1:0]) % sz);
    widx   = a[9:2];
    word   = longint'(ref_mem[widx]);
    mask   = ((64'd1 << (8*sz)) - 64'd1) << (8*bo);
    val    = (word & mask) >> (8*bo);
    if (sz < 4 && !uns && val[8*sz-1])
      val = val | (~((64'd1 << (8*sz)) - 64'd1) & 64'hFFFF_FFFF);
    merged = (word & ~mask) | ((longint'(d) << (8*bo)) & mask);
    sub    = legal && !trap && w && (sz < 4);

    @(posedge clk); #1;
    req_valid = v; req_we = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    e_addr = widx; e_ld = '0; e_stall = 1'b0; e_mis = 1'b0; e_we = 1'b0; e_dw = '0;
    if (legal) begin
      if (trap)         e_mis = 1'b1;
      else if (!w)      e_ld = val[31:0];
      else if (sz == 4) begin e_we = 1'b1; e_dw = d; end
      else              e_stall = 1'b1;
    end
    e_chk = 1'b1;
    @(negedge clk); #1;
    c_ld = ld_data; c_stall = stall; c_mis = misalign; c_we = dmem_MemRW;
    c_addr = dmem_Addr; c_dw = dmem_DataW;
    if (e_we) ref_mem[widx] = d;

    if (sub) begin
      @(posedge clk); #1;
      e_stall = 1'b0;
      if (abort) begin
        rst = 1'b1;
        e_we = 1'b0; e_dw = '0;
      end else begin
        e_we = 1'b1; e_dw = merged[31:0];
      end
      @(negedge clk); #1;
      c2_we = dmem_MemRW; c2_dw = dmem_DataW; c2_stall = stall;
      if (abort) begin
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk); #1;
      end else begin
        ref_mem[widx] = merged[31:0];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]  = 32'h80FF7F01; ref_mem[4]  = 32'h80FF7F01;
    mem[12] = 32'h11223344; ref_mem[12] = 32'h11223344;
    mem[16] = 32'hCAFEF00D; ref_mem[16] = 32'hCAFEF00D;
    mem[20] = 32'h01020304; ref_mem[20] = 32'h01020304;

    fork
      forever begin
        @(posedge clk);
        if (dmem_MemRW) mem[dmem_Addr] <= dmem_DataW;
      end
    join_none

    // reset holds every output quiet even with a word store presented
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk); #1;
    check("rst MemRW",   32'(dmem_MemRW), 32'h0);
    check("rst stall",   32'(stall),      32'h0);
    check("rst misalign",32'(misalign),   32'h0);
    check("rst ld_data", ld_data,         32'h0);
    check("rst DataW",   dmem_DataW,      32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;

    // loads from 0x80FF7F01
    do_txn(1, 0, 3'b000, 32'h10, 32'h0, 0); check("LB 0x10",  c_ld, 32'h00000001);
    do_txn(1, 0, 3'b000, 32'h12, 32'h0, 0); check("LB 0x12",  c_ld, 32'hFFFFFFFF);
    do_txn(1, 0, 3'b100, 32'h13, 32'h0, 0); check("LBU 0x13", c_ld, 32'h00000080);
    do_txn(1, 0, 3'b001, 32'h12, 32'h0, 0); check("LH 0x12",  c_ld, 32'hFFFF80FF);

    // single-cycle word store and readback
    do_txn(1, 1, 3'b010, 32'h20, 32'hDEADBEEF, 0);
    check("SW MemRW", 32'(c_we),    32'h1);
    check("SW Addr",  32'(c_addr),  32'h08);
    check("SW stall", 32'(c_stall), 32'h0);
    do_txn(1, 0, 3'b010, 32'h20, 32'h0, 0); check("LW 0x20", c_ld, 32'hDEADBEEF);

    // read-modify-write sub-word stores
    do_txn(1, 1, 3'b000, 32'h31, 32'hFFFFFFAA, 0);
    check("SB stall", 32'(c_stall), 32'h1);
    check("SB write", c2_dw,        32'h1122AA44);
    do_txn(1, 1, 3'b001, 32'h32, 32'h1234BEEF, 0);
    check("SH write", c2_dw,        32'hBEEFAA44);

    // misaligned word load
    do_txn(1, 0, 3'b010, 32'h41, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("LW 0x41 misalign", 32'(c_mis), 32'h1);
    check("LW 0x41 ld_data",  c_ld,       32'h0);
    check("LW 0x41 MemRW",    32'(c_we),  32'h0);
`else
    check("LW 0x41 ld_data",  c_ld,       32'hCAFEF00D);
    check("LW 0x41 misalign", 32'(c_mis), 32'h0);
`endif

    // reset during the write cycle aborts the store
    do_txn(1, 1, 3'b000, 32'h30, 32'h00000055, 1);
    check("abort MemRW", 32'(c2_we),    32'h0);
    check("abort stall", 32'(c2_stall), 32'h0);
    do_txn(1, 0, 3'b010, 32'h30, 32'h0, 0);
    check("after abort LW", c_ld, 32'hBEEFAA44);
    check("after abort stall", 32'(c_stall), 32'h0);

    // back-to-back store then load
    do_txn(1, 1, 3'b000, 32'h50, 32'h00000077, 0);
    do_txn(1, 0, 3'b010, 32'h50, 32'h0, 0);
    check("SB->LW 0x50", c_ld, 32'h01020377);

    // idle request
    do_txn(0, 1, 3'b010, 32'h60, 32'h0, 0);
    check("idle MemRW", 32'(c_we), 32'h0);

    for (int n = 0; n < 600; n++) begin
      do_txn(($urandom % 10) != 0, 1'($urandom), 3'($urandom), $urandom, $urandom, 0);
    end
    e_chk = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) check("final mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
